smem_arbiter: RTL and testbench
===============================

SMEM_ARBITER -- requirements
Module: smem_arbiter

Interface
REQ-001 Parameter NREQ, default 3, number of client ports; NREQ SHALL be between 2 and 8.
REQ-002 Parameter AW, default 8, address width; parameter DW, default 8, data width.
REQ-003 clk  input  1  system clock; all state SHALL update on the rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 req  input  NREQ  per-client access request, level-sensitive.
REQ-006 lock  input  NREQ  per-client grant hold for read-modify-write sequences.
REQ-007 wren  input  NREQ  per-client write enable (1=write, 0=read).
REQ-008 addr  input  NREQ x AW  per-client address.
REQ-009 wdata  input  NREQ x DW  per-client write data.
REQ-010 gnt  output  NREQ  one-hot grant; all zero when idle.
REQ-011 ack  output  NREQ  one-cycle completion pulse to the granted client.
REQ-012 rdata  output  DW  read data; valid in the ack cycle and held until the next read completes.
REQ-013 busy  output  1  high whenever the state is not IDLE.
REQ-014 mem_addr  output  AW; mem_data  output  DW; mem_wren  output  1  single-port RAM drive.
REQ-015 mem_q  input  DW  RAM read data, valid 2 cycles after mem_addr is presented.

Function
REQ-016 FSM states SHALL be IDLE, ISSUE, WAIT, DONE.
REQ-017 IDLE: if any req bit is high, pick a winner by round-robin, set gnt to the winner's one-hot value, latch the winner's wren/addr/wdata, and go to ISSUE; otherwise stay in IDLE.
REQ-018 Round-robin order SHALL start at (last_winner+1) mod NREQ and wrap; last_winner SHALL update on every grant.
REQ-019 ISSUE: drive the latched address and data onto mem_addr/mem_data, assert mem_wren iff the latched wren is 1, and go to WAIT.
REQ-020 mem_wren SHALL be 1 only in ISSUE; mem_addr/mem_data SHALL hold their last value in all other states.
REQ-021 WAIT: unconditional transition to DONE; this is the RAM settle cycle.
REQ-022 DONE: pulse ack for the winner; for reads, capture mem_q into rdata; for writes, leave rdata unchanged.
REQ-023 DONE exit: if lock and req of the winner are both high, keep gnt, re-latch the winner's inputs, and go to ISSUE without arbitrating; otherwise clear gnt and go to IDLE.
REQ-024 Latency: req sampled in IDLE at cycle N SHALL give ack at cycle N+3; a locked follow-on access SHALL give ack 3 cycles after the previous ack.
REQ-025 A client dropping req mid-access SHALL NOT abort the access; ack still pulses.
REQ-026 Clients' inputs SHALL be sampled only at grant and at locked re-latch; changes at other times SHALL be ignored.
REQ-027 A client holding req without lock after its ack SHALL re-arbitrate in IDLE like any other requester.
REQ-028 Simultaneous requests in IDLE SHALL produce exactly one grant; gnt and ack SHALL never have more than one bit set.

Reset
REQ-029 On reset: state=IDLE, gnt=0, ack=0, busy=0, mem_wren=0, mem_addr=0, mem_data=0, rdata=0, last_winner=NREQ-1 (client 0 has first priority).
REQ-030 Reset asserted mid-access SHALL abandon the access with no ack; mem_wren SHALL be 0 from the cycle after the reset edge.

Structure
REQ-031 The state enum and the default AW/DW constants SHALL live in shared package rc4_pkg.
REQ-032 Winner selection SHALL be a combinational sub-module rr_picker (inputs req and last_winner; output one-hot grant and index).

Verification
REQ-033 Single read: client1 reads addr 0x10 holding 0x5A -> gnt=3'b010 next cycle, ack[1] 3 cycles after req sampled, rdata=0x5A.
REQ-034 Write then read: client0 writes 0xA5 to 0xFF, then reads 0xFF -> mem_wren high for exactly 1 cycle, read returns 0xA5.
REQ-035 Contention: req=3'b111 held continuously, no lock -> grants in order 0,1,2,0, each 4 cycles apart.
REQ-036 Locked swap: client2 with lock reads 0x03, then 0x07, writes both back -> four consecutive acks with no intervening grant to clients 0/1 requesting throughout.
REQ-037 Reset in WAIT during a write -> no ack, gnt=0, busy=0, mem_wren=0 next cycle, and the next grant goes to client 0.
REQ-038 Client drops req in ISSUE -> ack still pulses in DONE, then IDLE.

Source files
------------

// File: rtl/rc4_pkg.sv
// Shared constants for the shared-memory arbiter: default bus widths and
// the legacy-compatible FSM state encodings.
package rc4_pkg;

  localparam int unsigned DEFAULT_AW = 8;
  localparam int unsigned DEFAULT_DW = 8;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE  = 2'd0;
  localparam state_t ST_ISSUE = 2'd1;
  localparam state_t ST_WAIT  = 2'd2;
  localparam state_t ST_DONE  = 2'd3;

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin winner selection: the search starts at the
// client after last_winner and wraps, returning one-hot grant and index.
module rr_picker #(
  parameter int unsigned NREQ = 3,
  parameter int unsigned IW   = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   last_winner,
  output logic [NREQ-1:0] grant,
  output logic [IW-1:0]   index
);

  logic          found;
  logic [IW-1:0] cand;

  // First requester found in rotating order from last_winner+1 wins
  always_comb begin
    grant = '0;
    index = '0;
    found = 1'b0;
    cand  = '0;
    for (int unsigned i = 1; i <= NREQ; i++) begin
      cand = IW'((32'(last_winner) + i) % NREQ);
      if (!found && req[cand]) begin
        found       = 1'b1;
        grant[cand] = 1'b1;
        index       = cand;
      end
    end
  end

endmodule

// File: rtl/smem_arbiter.sv
// Round-robin arbiter giving NREQ clients access to one single-port RAM
// with a two-cycle read latency. Each access runs IDLE/ISSUE/WAIT/DONE;
// a client holding lock keeps the grant for back-to-back accesses.
module smem_arbiter
  import rc4_pkg::*;
#(
  parameter int unsigned NREQ = 3,
  parameter int unsigned AW   = DEFAULT_AW,
  parameter int unsigned DW   = DEFAULT_DW
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [NREQ-1:0]  req,
  input  logic [NREQ-1:0]  lock,
  input  logic [NREQ-1:0]  wren,
  input  logic [NREQ*AW-1:0] addr,
  input  logic [NREQ*DW-1:0] wdata,
  output logic [NREQ-1:0]  gnt,
  output logic [NREQ-1:0]  ack,
  output logic [DW-1:0]    rdata,
  output logic             busy,
  output logic [AW-1:0]    mem_addr,
  output logic [DW-1:0]    mem_data,
  output logic             mem_wren,
  input  logic [DW-1:0]    mem_q
);

  localparam int unsigned IW = $clog2(NREQ);

  state_t          state;
  logic [IW-1:0]   last_winner;
  logic [IW-1:0]   winner;
  logic            wren_q;

  logic [NREQ-1:0] pick_grant;
  logic [IW-1:0]   pick_index;

  logic [IW-1:0]   sel;
  logic            sel_wren;
  logic [AW-1:0]   sel_addr;
  logic [DW-1:0]   sel_wdata;

  rr_picker #(
    .NREQ (NREQ),
    .IW   (IW)
  ) u_picker (
    .req         (req),
    .last_winner (last_winner),
    .grant       (pick_grant),
    .index       (pick_index)
  );

  // Client whose inputs get latched: the new winner in IDLE, else the current owner
  always_comb begin
    sel       = (state == ST_IDLE) ? pick_index : winner;
    sel_wren  = wren[sel];
    sel_addr  = addr[32'(sel)*AW +: AW];
    sel_wdata = wdata[32'(sel)*DW +: DW];
  end

  // The latched address/data registers double as the RAM drive, so the RAM
  // sees them from ISSUE onward and they hold between accesses.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= ST_IDLE;
      gnt         <= '0;
      ack         <= '0;
      rdata       <= '0;
      last_winner <= IW'(NREQ - 1);
      winner      <= '0;
      wren_q      <= 1'b0;
      mem_addr    <= '0;
      mem_data    <= '0;
    end else begin
      ack <= '0;
      case (state)
        ST_IDLE: begin
          if (|req) begin
            gnt         <= pick_grant;
            winner      <= pick_index;
            last_winner <= pick_index;
            wren_q      <= sel_wren;
            mem_addr    <= sel_addr;
            mem_data    <= sel_wdata;
            state       <= ST_ISSUE;
          end
        end
        ST_ISSUE: state <= ST_WAIT;
        ST_WAIT:  state <= ST_DONE;
        ST_DONE: begin
          ack <= gnt;
          if (!wren_q) begin
            rdata <= mem_q;
          end
          if (lock[winner] && req[winner]) begin
            wren_q   <= sel_wren;
            mem_addr <= sel_addr;
            mem_data <= sel_wdata;
            state    <= ST_ISSUE;
          end else begin
            gnt   <= '0;
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign mem_wren = (state == ST_ISSUE) && wren_q;
  assign busy     = (state != ST_IDLE);

endmodule

// File: tb/tb_smem_arbiter.sv
// Self-checking bench for smem_arbiter with a behavioural two-cycle RAM.
module tb_smem_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic [2:0]  req, lock, wren;
  logic [23:0] addr, wdata;
  logic [2:0]  gnt, ack;
  logic [7:0]  rdata;
  logic        busy;
  logic [7:0]  mem_addr, mem_data, mem_q;
  logic        mem_wren;

  logic        preload;
  logic [7:0]  ram [256];
  logic [7:0]  q1;
  logic [7:0]  refmem [256];

  int unsigned checks = 0;
  int unsigned passed = 0;

  smem_arbiter #(.NREQ(3), .AW(8), .DW(8)) dut (
    .clk(clk), .reset(reset), .req(req), .lock(lock), .wren(wren),
    .addr(addr), .wdata(wdata), .gnt(gnt), .ack(ack), .rdata(rdata),
    .busy(busy), .mem_addr(mem_addr), .mem_data(mem_data),
    .mem_wren(mem_wren), .mem_q(mem_q)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] init_val(logic [7:0] a);
    return (a == 8'h10) ? 8'h5A : (a ^ 8'h3C);
  endfunction

  // RAM: write on mem_wren, read data appears two edges after the address
  always @(posedge clk) begin
    if (preload) begin
      for (int i = 0; i < 256; i++) ram[i] <= init_val(8'(i));
    end else if (mem_wren) begin
      ram[mem_addr] <= mem_data;
    end
    q1    <= ram[mem_addr];
    mem_q <= q1;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic set_client(int unsigned c, bit w, logic [7:0] a, logic [7:0] d);
    wren[c]        = w;
    addr[c*8 +: 8]  = a;
    wdata[c*8 +: 8] = d;
  endtask

  // One unlocked access from IDLE; optionally drops req and scrambles inputs mid-access
  task automatic access(int unsigned c, bit w, logic [7:0] a, logic [7:0] d,
                        bit drop, logic [7:0] exp_rd);
    logic [2:0] oh;
    oh = 3'(1 << c);
    set_client(c, w, a, d);
    lock = '0;
    req  = oh;
    tick();
    chk("acc_gnt", gnt, oh);
    chk("acc_busy", busy, 1);
    chk("acc_issue_wren", mem_wren, w);
    chk("acc_issue_addr", mem_addr, a);
    if (w) chk("acc_issue_data", mem_data, d);
    if (drop) begin
      req = '0;
      set_client(c, ~w, a + 8'd1, d + 8'd1);
    end
    tick();
    chk("acc_wait_wren", mem_wren, 0);
    chk("acc_wait_addr", mem_addr, a);
    chk("acc_wait_gnt", gnt, oh);
    tick();
    chk("acc_done_ack", ack, 0);
    chk("acc_done_wren", mem_wren, 0);
    req = '0;
    tick();
    chk("acc_ack", ack, oh);
    chk("acc_gnt_clr", gnt, 0);
    chk("acc_idle", busy, 0);
    chk("acc_rdata", rdata, exp_rd);
    if (w) refmem[a] = d;
  endtask

  typedef struct {
    int unsigned client;
    bit          wr;
    logic [7:0]  a;
    logic [7:0]  d;
    bit          drop;
    logic [7:0]  rd;
  } vec_t;

  vec_t vecs[8];

  initial begin
    logic [7:0]  v3, v7;
    bit          sw_w [4];
    logic [7:0]  sw_a [4], sw_d [4], sw_rd [4];
    // reference model state
    bit          m_active;
    int unsigned m_owner, m_last, m_left, cc;
    bit          m_w, found;
    logic [7:0]  m_a, m_d, m_rdata;
    logic [2:0]  exp_ack, exp_gnt;

    for (int i = 0; i < 256; i++) refmem[i] = init_val(8'(i));
    req = '0; lock = '0; wren = '0; addr = '0; wdata = '0;
    preload = 1'b1;
    reset   = 1'b1;
    tick();
    tick();
    preload = 1'b0;
    chk("rst_gnt", gnt, 0);
    chk("rst_ack", ack, 0);
    chk("rst_busy", busy, 0);
    chk("rst_wren", mem_wren, 0);
    chk("rst_addr", mem_addr, 0);
    chk("rst_data", mem_data, 0);
    chk("rst_rdata", rdata, 0);
    reset = 1'b0;
    tick();

    // Single accesses: reads, writes, read-back, req dropped mid-access
    vecs[0] = '{1, 1'b0, 8'h10, 8'h00, 1'b0, 8'h5A};
    vecs[1] = '{0, 1'b1, 8'hFF, 8'hA5, 1'b0, 8'h5A};
    vecs[2] = '{0, 1'b0, 8'hFF, 8'h00, 1'b0, 8'hA5};
    vecs[3] = '{2, 1'b1, 8'h03, 8'hC3, 1'b1, 8'hA5};
    vecs[4] = '{1, 1'b0, 8'h03, 8'h00, 1'b1, 8'hC3};
    vecs[5] = '{2, 1'b0, 8'h07, 8'h00, 1'b0, 8'h3B};
    vecs[6] = '{0, 1'b1, 8'h00, 8'h00, 1'b0, 8'h3B};
    vecs[7] = '{2, 1'b0, 8'h00, 8'h00, 1'b0, 8'h00};
    for (int i = 0; i < 8; i++)
      access(vecs[i].client, vecs[i].wr, vecs[i].a, vecs[i].d, vecs[i].drop, vecs[i].rd);

    // Locked swap of 0x03 and 0x07 by client 2 while clients 0/1 request
    v3 = refmem[8'h03];
    v7 = refmem[8'h07];
    sw_w  = '{1'b0, 1'b0, 1'b1, 1'b1};
    sw_a  = '{8'h03, 8'h07, 8'h03, 8'h07};
    sw_d  = '{8'h00, 8'h00, v7, v3};
    sw_rd = '{v3, v7, v7, v7};
    set_client(2, sw_w[0], sw_a[0], sw_d[0]);
    lock = 3'b100;
    req  = 3'b100;
    tick();
    chk("swap_gnt0", gnt, 3'b100);
    req = 3'b111;
    for (int j = 0; j < 4; j++) begin
      chk("swap_issue_wren", mem_wren, sw_w[j]);
      chk("swap_issue_addr", mem_addr, sw_a[j]);
      tick();
      chk("swap_wait_gnt", gnt, 3'b100);
      tick();
      chk("swap_done_ack", ack, 0);
      if (j < 3) set_client(2, sw_w[j+1], sw_a[j+1], sw_d[j+1]);
      else lock = '0;
      tick();
      chk("swap_ack", ack, 3'b100);
      chk("swap_rdata", rdata, sw_rd[j]);
      chk("swap_gnt_after", gnt, (j < 3) ? 3'b100 : 3'b000);
    end
    req = '0;
    refmem[8'h03] = v7;
    refmem[8'h07] = v3;
    access(0, 1'b0, 8'h03, 8'h00, 1'b0, v7);
    access(1, 1'b0, 8'h07, 8'h00, 1'b0, v3);

    // Reset during WAIT of a write abandons it; client 0 then has priority
    set_client(1, 1'b1, 8'hEE, 8'h77);
    req = 3'b010;
    tick();
    chk("rstw_gnt", gnt, 3'b010);
    req = '0;
    tick();
    reset = 1'b1;
    tick();
    chk("rstw_ack", ack, 0);
    chk("rstw_gnt0", gnt, 0);
    chk("rstw_busy", busy, 0);
    chk("rstw_wren", mem_wren, 0);
    chk("rstw_rdata", rdata, 0);
    reset = 1'b0;

    // Contention: all three hold req, no lock -> 0,1,2,0 every 4 cycles
    wren = '0;
    lock = '0;
    req  = 3'b111;
    for (int k = 1; k <= 16; k++) begin
      tick();
      cc = ((k - 1) / 4) % 3;
      chk("cont_gnt", gnt, ((k - 1) % 4 < 3) ? 3'(1 << cc) : 3'b000);
      chk("cont_ack", ack, ((k - 1) % 4 == 3) ? 3'(1 << cc) : 3'b000);
    end
    req = '0;
    tick(); tick(); tick(); tick();

    // Randomized traffic against a transaction-level model
    reset = 1'b1;
    tick();
    reset = 1'b0;
    m_active = 1'b0; m_last = 2; m_owner = 0; m_left = 0;
    m_w = 1'b0; m_a = '0; m_d = '0; m_rdata = '0;
    for (int n = 0; n < 600; n++) begin
      req  = 3'($urandom) | 3'($urandom);
      if ($urandom_range(0, 4) == 0) req = '0;
      lock = 3'($urandom) & 3'($urandom);
      wren = 3'($urandom);
      for (int c = 0; c < 3; c++) begin
        addr[c*8 +: 8]  = 8'($urandom_range(0, 15));
        wdata[c*8 +: 8] = 8'($urandom);
      end
      exp_ack = '0;
      if (!m_active) begin
        if (req != 0) begin
          found = 1'b0;
          for (int i = 1; i <= 3; i++) begin
            cc = (m_last + i) % 3;
            if (!found && req[cc]) begin
              found = 1'b1;
              m_owner = cc;
            end
          end
          m_last = m_owner;
          m_active = 1'b1;
          m_left = 3;
          m_w = wren[m_owner]; m_a = addr[m_owner*8 +: 8]; m_d = wdata[m_owner*8 +: 8];
        end
      end else begin
        m_left--;
        if (m_left == 0) begin
          exp_ack = 3'(1 << m_owner);
          if (m_w) refmem[m_a] = m_d;
          else m_rdata = refmem[m_a];
          if (lock[m_owner] && req[m_owner]) begin
            m_left = 3;
            m_w = wren[m_owner]; m_a = addr[m_owner*8 +: 8]; m_d = wdata[m_owner*8 +: 8];
          end else begin
            m_active = 1'b0;
          end
        end
      end
      exp_gnt = m_active ? 3'(1 << m_owner) : 3'b000;
      tick();
      chk("rnd_gnt", gnt, exp_gnt);
      chk("rnd_ack", ack, exp_ack);
      chk("rnd_busy", busy, m_active);
      chk("rnd_wren", mem_wren, m_active && m_left == 3 && m_w);
      chk("rnd_rdata", rdata, m_rdata);
      if (m_active) chk("rnd_addr", mem_addr, m_a);
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
